// File: rtl/demux_pkg.sv
// demux_pkg: shared constants for the level-1 2-to-4 demux scheduler.
// Holds the FSM state encoding, default datapath widths and output lane indices.
package demux_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned CNT_W_DEF  = 8;

  // Output lane indices; lanes 0/1 are fed from input lane 0, lanes 2/3 from input lane 1
  localparam int unsigned LANE0 = 0;
  localparam int unsigned LANE1 = 1;
  localparam int unsigned LANE2 = 2;
  localparam int unsigned LANE3 = 3;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACTIVE = 2'd2
  } state_e;

endpackage : demux_pkg

// File: rtl/demux_pair_sched.sv
// demux_pair_sched: steers one input lane alternately onto two output lanes (a, b).
// Ports:
//   clk, reset_L        word clock, synchronous active-high reset
//   allow               scheduler permits accepts this cycle (not INIT, enabled)
//   valid_in, data_in   input word
//   lane_ready[1:0]     bit 0 = lane a can take a word, bit 1 = lane b
//   ready_c, acc_c      combinational ready / accept for the input lane
//   valid_out_a/b, data_out_a/b, cnt_a/b   registered output lanes and word counters
module demux_pair_sched
  import demux_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              allow,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic [1:0]        lane_ready,
  output logic              ready_c,
  output logic              acc_c,
  output logic              valid_out_a,
  output logic              valid_out_b,
  output logic [DATA_W-1:0] data_out_a,
  output logic [DATA_W-1:0] data_out_b,
  output logic [CNT_W-1:0]  cnt_a,
  output logic [CNT_W-1:0]  cnt_b
);

  // 0 -> next word goes to lane a, 1 -> lane b
  logic sel;

  // Strict alternation: a blocked destination stalls the input, never skips to the sibling
  assign ready_c = allow & lane_ready[sel];
  assign acc_c   = valid_in & ready_c;

  // Output lanes, counters and pointer; data holds when no word is delivered
  always_ff @(posedge clk) begin
    if (reset_L) begin
      sel         <= 1'b0;
      valid_out_a <= 1'b0;
      valid_out_b <= 1'b0;
      data_out_a  <= '0;
      data_out_b  <= '0;
      cnt_a       <= '0;
      cnt_b       <= '0;
    end else begin
      valid_out_a <= acc_c & ~sel;
      valid_out_b <= acc_c & sel;
      if (acc_c) begin
        sel <= ~sel;
        if (sel) begin
          data_out_b <= data_in;
          cnt_b      <= cnt_b + CNT_W'(1);
        end else begin
          data_out_a <= data_in;
          cnt_a      <= cnt_a + CNT_W'(1);
        end
      end
    end
  end

endmodule : demux_pair_sched

// File: rtl/demux_l1_sched.sv
// demux_l1_sched: level-1 2-to-4 demux scheduler in the clk_2f word domain.
// Input lane 0 alternates onto output lanes 0/1, input lane 1 onto lanes 2/3.
// Ports:
//   clk, reset_L                  word clock, synchronous active-high reset
//   enable                        global accept enable
//   valid_in0/1, data_in0/1       input lanes
//   lane_ready[3:0]               per-output-lane space available
//   ready_out0/1                  combinational accept indication per input lane
//   valid_out0..3, data_out0..3   registered output lanes
//   cnt_lane0..3                  words delivered per output lane (wrapping)
//   busy                          registered, high while in ACTIVE
module demux_l1_sched
  import demux_pkg::*;
#(
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned CNT_W        = CNT_W_DEF,
  parameter int unsigned INIT_CYCLES  = 2,
  parameter int unsigned IDLE_TIMEOUT = 4
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              enable,
  input  logic              valid_in0,
  input  logic              valid_in1,
  input  logic [DATA_W-1:0] data_in0,
  input  logic [DATA_W-1:0] data_in1,
  input  logic [3:0]        lane_ready,
  output logic              ready_out0,
  output logic              ready_out1,
  output logic              valid_out0,
  output logic              valid_out1,
  output logic              valid_out2,
  output logic              valid_out3,
  output logic [DATA_W-1:0] data_out0,
  output logic [DATA_W-1:0] data_out1,
  output logic [DATA_W-1:0] data_out2,
  output logic [DATA_W-1:0] data_out3,
  output logic [CNT_W-1:0]  cnt_lane0,
  output logic [CNT_W-1:0]  cnt_lane1,
  output logic [CNT_W-1:0]  cnt_lane2,
  output logic [CNT_W-1:0]  cnt_lane3,
  output logic              busy
);

  localparam int unsigned INIT_W = (INIT_CYCLES > 2) ? $clog2(INIT_CYCLES) : 1;
  localparam int unsigned IDLE_W = (IDLE_TIMEOUT > 2) ? $clog2(IDLE_TIMEOUT) : 1;

  state_e            state_q, state_d;
  logic [INIT_W-1:0] init_cnt_q, init_cnt_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic              allow;
  logic              acc0, acc1, any_acc;

  assign allow   = (state_q != ST_INIT) & enable;
  assign any_acc = acc0 | acc1;

  // Pair 0: input lane 0 -> output lanes 0/1
  demux_pair_sched #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_pair01 (
    .clk         (clk),
    .reset_L     (reset_L),
    .allow       (allow),
    .valid_in    (valid_in0),
    .data_in     (data_in0),
    .lane_ready  (lane_ready[LANE1:LANE0]),
    .ready_c     (ready_out0),
    .acc_c       (acc0),
    .valid_out_a (valid_out0),
    .valid_out_b (valid_out1),
    .data_out_a  (data_out0),
    .data_out_b  (data_out1),
    .cnt_a       (cnt_lane0),
    .cnt_b       (cnt_lane1)
  );

  // Pair 1: input lane 1 -> output lanes 2/3
  demux_pair_sched #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_pair23 (
    .clk         (clk),
    .reset_L     (reset_L),
    .allow       (allow),
    .valid_in    (valid_in1),
    .data_in     (data_in1),
    .lane_ready  (lane_ready[LANE3:LANE2]),
    .ready_c     (ready_out1),
    .acc_c       (acc1),
    .valid_out_a (valid_out2),
    .valid_out_b (valid_out3),
    .data_out_a  (data_out2),
    .data_out_b  (data_out3),
    .cnt_a       (cnt_lane2),
    .cnt_b       (cnt_lane3)
  );

  // State, counters and busy; busy is taken from the next state so it matches state_q
  always_ff @(posedge clk) begin
    if (reset_L) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
      idle_cnt_q <= '0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      busy       <= (state_d == ST_ACTIVE);
    end
  end

  // Next-state: INIT for a fixed count, IDLE until traffic, ACTIVE until a quiet timeout
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    idle_cnt_d = idle_cnt_q;
    case (state_q)
      ST_INIT: begin
        if (init_cnt_q == INIT_W'(INIT_CYCLES - 1)) begin
          state_d    = ST_IDLE;
          init_cnt_d = '0;
        end else begin
          init_cnt_d = init_cnt_q + INIT_W'(1);
        end
      end
      ST_IDLE: begin
        if (any_acc) begin
          state_d    = ST_ACTIVE;
          idle_cnt_d = '0;
        end
      end
      ST_ACTIVE: begin
        if (any_acc) begin
          idle_cnt_d = '0;
        end else if (idle_cnt_q == IDLE_W'(IDLE_TIMEOUT - 1)) begin
          state_d    = ST_IDLE;
          idle_cnt_d = '0;
        end else begin
          idle_cnt_d = idle_cnt_q + IDLE_W'(1);
        end
      end
      default: begin
        state_d    = ST_INIT;
        init_cnt_d = '0;
        idle_cnt_d = '0;
      end
    endcase
  end

endmodule : demux_l1_sched

// File: tb/tb_demux_l1_sched.sv
// tb_demux_l1_sched: directed plus randomized stimulus for demux_l1_sched, checked
// every cycle against a lane-level behavioural model.
module tb_demux_l1_sched;

  localparam int DATA_W       = 8;
  localparam int CNT_W        = 8;
  localparam int INIT_CYCLES  = 2;
  localparam int IDLE_TIMEOUT = 4;

  logic              clk = 1'b0;
  logic              reset_L = 1'b1;
  logic              enable = 1'b0;
  logic              valid_in0 = 1'b0, valid_in1 = 1'b0;
  logic [DATA_W-1:0] data_in0 = '0, data_in1 = '0;
  logic [3:0]        lane_ready = '0;
  logic              ready_out0, ready_out1;
  logic              valid_out0, valid_out1, valid_out2, valid_out3;
  logic [DATA_W-1:0] data_out0, data_out1, data_out2, data_out3;
  logic [CNT_W-1:0]  cnt_lane0, cnt_lane1, cnt_lane2, cnt_lane3;
  logic              busy;

  always #5 clk = ~clk;

  demux_l1_sched #(
    .DATA_W(DATA_W), .CNT_W(CNT_W), .INIT_CYCLES(INIT_CYCLES), .IDLE_TIMEOUT(IDLE_TIMEOUT)
  ) dut (
    .clk(clk), .reset_L(reset_L), .enable(enable),
    .valid_in0(valid_in0), .valid_in1(valid_in1),
    .data_in0(data_in0), .data_in1(data_in1), .lane_ready(lane_ready),
    .ready_out0(ready_out0), .ready_out1(ready_out1),
    .valid_out0(valid_out0), .valid_out1(valid_out1),
    .valid_out2(valid_out2), .valid_out3(valid_out3),
    .data_out0(data_out0), .data_out1(data_out1),
    .data_out2(data_out2), .data_out3(data_out3),
    .cnt_lane0(cnt_lane0), .cnt_lane1(cnt_lane1),
    .cnt_lane2(cnt_lane2), .cnt_lane3(cnt_lane3),
    .busy(busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: per-lane delivered word, valid and count; per-input next lane
  int  m_mode;          // 0 = INIT, 1 = IDLE, 2 = ACTIVE
  int  m_init_left;
  int  m_quiet;
  int  m_next[2];       // which lane of the pair receives the next word (0 or 1)
  int  m_cnt[4];
  bit  m_val[4];
  int  m_dat[4];
  bit  m_known = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] dout(input int k);
    case (k)
      0: return data_out0;
      1: return data_out1;
      2: return data_out2;
      default: return data_out3;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] cout(input int k);
    case (k)
      0: return cnt_lane0;
      1: return cnt_lane1;
      2: return cnt_lane2;
      default: return cnt_lane3;
    endcase
  endfunction

  // One clock cycle: drive, check ready, clock, update model, check registered outputs
  task automatic step(input bit r, input bit en, input bit v0, input bit v1,
                      input logic [7:0] d0, input logic [7:0] d1, input logic [3:0] lr);
    bit rdy[2];
    bit acc[2];
    bit vin[2];
    int din[2];
    logic [3:0] vo;
    @(negedge clk);
    reset_L = r; enable = en; valid_in0 = v0; valid_in1 = v1;
    data_in0 = d0; data_in1 = d1; lane_ready = lr;
    #1;
    vin[0] = v0; vin[1] = v1; din[0] = int'(d0); din[1] = int'(d1);
    for (int p = 0; p < 2; p++) begin
      rdy[p] = (m_mode != 0) && en && lr[2*p + m_next[p]];
      acc[p] = vin[p] && rdy[p];
    end
    if (m_known) begin
      check("ready_out0", 32'(ready_out0), 32'(rdy[0]));
      check("ready_out1", 32'(ready_out1), 32'(rdy[1]));
    end
    @(posedge clk);
    if (r) begin
      m_mode = 0; m_init_left = INIT_CYCLES; m_quiet = 0;
      m_next[0] = 0; m_next[1] = 0;
      for (int k = 0; k < 4; k++) begin m_cnt[k] = 0; m_val[k] = 0; m_dat[k] = 0; end
      m_known = 1'b1;
    end else begin
      for (int p = 0; p < 2; p++) begin
        m_val[2*p] = 0; m_val[2*p+1] = 0;
        if (acc[p]) begin
          m_val[2*p + m_next[p]] = 1;
          m_dat[2*p + m_next[p]] = din[p];
          m_cnt[2*p + m_next[p]] = (m_cnt[2*p + m_next[p]] + 1) % (1 << CNT_W);
          m_next[p] = 1 - m_next[p];
        end
      end
      case (m_mode)
        0: begin m_init_left--; if (m_init_left == 0) m_mode = 1; end
        1: if (acc[0] || acc[1]) begin m_mode = 2; m_quiet = 0; end
        default: begin
          if (acc[0] || acc[1]) m_quiet = 0;
          else m_quiet++;
          if (m_quiet == IDLE_TIMEOUT) begin m_mode = 1; m_quiet = 0; end
        end
      endcase
    end
    #1;
    if (m_known) begin
      vo = {valid_out3, valid_out2, valid_out1, valid_out0};
      for (int k = 0; k < 4; k++) begin
        check($sformatf("valid_out%0d", k), 32'(vo[k]), 32'(m_val[k]));
        check($sformatf("data_out%0d", k), 32'(dout(k)), 32'(m_dat[k]));
        check($sformatf("cnt_lane%0d", k), 32'(cout(k)), 32'(m_cnt[k]));
      end
      check("busy", 32'(busy), 32'(m_mode == 2));
    end
  endtask

  initial begin
    logic [7:0] alt_d[4];
    logic [7:0] cc_d[2];
    alt_d[0] = 8'h10; alt_d[1] = 8'h1F; alt_d[2] = 8'h23; alt_d[3] = 8'h2D;
    cc_d[0]  = 8'h08; cc_d[1]  = 8'h11;

    // Reset for two cycles, then INIT and IDLE with all lanes ready
    step(1, 0, 0, 0, 8'h00, 8'h00, 4'hF);
    step(1, 0, 0, 0, 8'h00, 8'h00, 4'hF);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 8'h00, 8'h00, 4'hF);

    // Alternation on input lane 0
    for (int i = 0; i < 4; i++) step(0, 1, 1, 0, alt_d[i], 8'h00, 4'hF);
    step(0, 1, 0, 0, 8'h00, 8'h00, 4'hF);
    check("alt_cnt_lane0", 32'(cnt_lane0), 32'd2);
    check("alt_cnt_lane1", 32'(cnt_lane1), 32'd2);

    // Concurrent pairs
    for (int i = 0; i < 2; i++) step(0, 1, 1, 1, 8'h44 + 8'(i), cc_d[i], 4'hF);
    check("cc_data_out3", 32'(data_out3), 32'h11);

    // Backpressure on lane 1 after pointer moves to it
    step(0, 1, 1, 0, 8'h66, 8'h00, 4'hF);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 8'h77, 8'h00, 4'b1101);
    step(0, 1, 1, 0, 8'h77, 8'h00, 4'hF);
    check("bp_data_out1", 32'(data_out1), 32'h77);

    // 512 words on input lane 1 -> 256 to lane 2, wrapping its counter; then quiet timeout
    for (int i = 0; i < 512; i++) step(0, 1, 0, 1, 8'h00, 8'(i), 4'hF);
    for (int i = 0; i < IDLE_TIMEOUT; i++) step(0, 1, 0, 0, 8'h00, 8'h00, 4'hF);
    check("timeout_busy", 32'(busy), 32'd0);

    // Mid-stream reset during traffic, then restart at lanes 0/2
    for (int i = 0; i < 3; i++) step(0, 1, 1, 1, 8'hA0 + 8'(i), 8'hB0 + 8'(i), 4'hF);
    step(1, 1, 1, 1, 8'hEE, 8'hEE, 4'hF);
    for (int i = 0; i < 4; i++) step(0, 1, 1, 1, 8'hC0 + 8'(i), 8'hD0 + 8'(i), 4'hF);

    // Randomized traffic with backpressure, enable gaps and occasional reset
    for (int i = 0; i < 2500; i++) begin
      step($urandom_range(0, 299) == 0, $urandom_range(0, 9) != 0,
           $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7,
           8'($urandom), 8'($urandom), 4'($urandom) | 4'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_demux_l1_sched
